// File: rtl/alu_seq_core.sv
// ALU execution core: one registered result per accepted command.
// MUL runs as a DATASIZE-step shift-add; every other op takes one cycle.
module alu_seq_core #(
  parameter int DATASIZE   = 8,
  parameter int OUTPUTSIZE = 2*DATASIZE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_op,
  input  logic [DATASIZE-1:0]   in_a,
  input  logic [DATASIZE-1:0]   in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUTPUTSIZE-1:0] out_result,
  output logic                  out_carry,
  output logic                  out_zero
);

  localparam int SHW  = $clog2(DATASIZE);
  localparam int PADW = OUTPUTSIZE - DATASIZE;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL_BUSY,
    S_HOLD
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [DATASIZE-1:0]   r_a;
  logic [DATASIZE-1:0]   r_b;
  logic [OUTPUTSIZE-1:0] r_acc;
  logic [SHW-1:0]        r_cnt;
  logic [OUTPUTSIZE-1:0] r_result;
  logic                  r_carry;
  logic                  r_zero;
  logic                  r_valid;

  logic                  w_accept;
  logic                  w_mul_last;
  logic [DATASIZE:0]     w_sum;
  logic [DATASIZE-1:0]   w_diff;
  logic [OUTPUTSIZE-1:0] w_in_a_ext;
  logic [OUTPUTSIZE-1:0] w_r_a_ext;
  logic [OUTPUTSIZE-1:0] w_acc_nxt;
  logic [OUTPUTSIZE-1:0] w_res;
  logic                  w_cy;

  assign in_ready   = (r_state == S_IDLE) && rst_n;
  assign w_accept   = in_valid && in_ready;
  assign w_mul_last = (r_state == S_MUL_BUSY) &&
                      (r_cnt == SHW'(DATASIZE-1));

  assign w_sum      = {1'b0, in_a} + {1'b0, in_b};
  assign w_diff     = in_a - in_b;
  assign w_in_a_ext = {{PADW{1'b0}}, in_a};
  assign w_r_a_ext  = {{PADW{1'b0}}, r_a};
  assign w_acc_nxt  = r_b[r_cnt] ? r_acc + (w_r_a_ext << r_cnt) : r_acc;

  always_comb begin
    w_res = '0;
    w_cy  = 1'b0;
    unique case (in_op)
      OP_ADD: begin
        w_res = {{(PADW-1){1'b0}}, w_sum};
        w_cy  = w_sum[DATASIZE];
      end
      OP_SUB: begin
        w_res = {{PADW{1'b0}}, w_diff};
        w_cy  = (in_a < in_b);
      end
      OP_MUL: w_res = '0;
      OP_AND: w_res = {{PADW{1'b0}}, in_a & in_b};
      OP_OR:  w_res = {{PADW{1'b0}}, in_a | in_b};
      OP_XOR: w_res = {{PADW{1'b0}}, in_a ^ in_b};
      OP_SHL: w_res = w_in_a_ext << in_b[SHW-1:0];
      OP_SHR: w_res = {{PADW{1'b0}}, in_a >> in_b[SHW-1:0]};
    endcase
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (w_accept)
          w_next = (in_op == OP_MUL) ? S_MUL_BUSY : S_HOLD;
      S_MUL_BUSY:
        if (w_mul_last) w_next = S_HOLD;
      S_HOLD:
        if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      if (w_accept) begin
        if (in_op == OP_MUL) begin
          r_a   <= in_a;
          r_b   <= in_b;
          r_acc <= '0;
          r_cnt <= '0;
        end else begin
          r_result <= w_res;
          r_carry  <= w_cy;
          r_zero   <= (w_res == '0);
          r_valid  <= 1'b1;
        end
      end
      if (r_state == S_MUL_BUSY) begin
        r_acc <= w_acc_nxt;
        r_cnt <= r_cnt + 1'b1;
        if (w_mul_last) begin
          r_result <= w_acc_nxt;
          r_carry  <= 1'b0;
          r_zero   <= (w_acc_nxt == '0);
          r_valid  <= 1'b1;
        end
      end
      if (r_state == S_HOLD && out_ready)
        r_valid <= 1'b0;
    end
  end

  assign out_valid  = r_valid;
  assign out_result = r_result;
  assign out_carry  = r_carry;
  assign out_zero   = r_zero;

endmodule

// File: tb/tb_alu_seq_core.sv
// Directed-vector bench for alu_seq_core.
// Inputs change 1ns after posedge; outputs are sampled there too.
module tb_alu_seq_core;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic        out_carry;
  logic        out_zero;

  int checks = 0;
  int errors = 0;

  alu_seq_core #(.DATASIZE(8), .OUTPUTSIZE(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_carry (out_carry),
    .out_zero  (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op,
                       input logic [7:0] a,
                       input logic [7:0] b);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready got %b exp 0", in_ready);
    end
    checks++;
    if ({out_valid, out_carry, out_zero, out_result} !== 19'd0) begin
      errors++;
      $display("FAIL reset_outs got v%b c%b z%b r%h exp all 0",
               out_valid, out_carry, out_zero, out_result);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_in_ready got %b exp 1", in_ready);
    end
  endtask

  task automatic test_add();
    issue(3'b000, 8'd200, 8'd100);
    checks++;
    if ({out_valid, out_result, out_carry, out_zero} !==
        {1'b1, 16'h012C, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL add_200_100 got v%b r%h c%b z%b exp v1 r012c c1 z0",
               out_valid, out_result, out_carry, out_zero);
    end
    drain();
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL add_drain got v%b rdy%b exp v0 rdy1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_sub();
    issue(3'b001, 8'd5, 8'd7);
    checks++;
    if ({out_valid, out_result, out_carry, out_zero} !==
        {1'b1, 16'h00FE, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL sub_5_7 got v%b r%h c%b z%b exp v1 r00fe c1 z0",
               out_valid, out_result, out_carry, out_zero);
    end
    drain();
    issue(3'b001, 8'd7, 8'd7);
    checks++;
    if ({out_valid, out_result, out_carry, out_zero} !==
        {1'b1, 16'h0000, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL sub_7_7 got v%b r%h c%b z%b exp v1 r0000 c0 z1",
               out_valid, out_result, out_carry, out_zero);
    end
    drain();
  endtask

  task automatic test_logic();
    issue(3'b011, 8'hF0, 8'h3C);
    checks++;
    if ({out_result, out_carry} !== {16'h0030, 1'b0}) begin
      errors++;
      $display("FAIL and got r%h c%b exp r0030 c0", out_result, out_carry);
    end
    drain();
    issue(3'b100, 8'hF0, 8'h3C);
    checks++;
    if (out_result !== 16'h00FC) begin
      errors++;
      $display("FAIL or got %h exp 00fc", out_result);
    end
    drain();
    issue(3'b101, 8'hF0, 8'h3C);
    checks++;
    if (out_result !== 16'h00CC) begin
      errors++;
      $display("FAIL xor got %h exp 00cc", out_result);
    end
    drain();
  endtask

  task automatic test_mul();
    int cyc;
    issue(3'b010, 8'd255, 8'd255);
    cyc = 1;
    checks++;
    if ({out_valid, in_ready} !== 2'b00) begin
      errors++;
      $display("FAIL mul_busy got v%b rdy%b exp v0 rdy0",
               out_valid, in_ready);
    end
    while (out_valid !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    checks++;
    if (cyc != 9) begin
      errors++;
      $display("FAIL mul_latency got %0d exp 9", cyc);
    end
    checks++;
    if ({out_result, out_carry, out_zero} !== {16'hFE01, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mul_255_255 got r%h c%b z%b exp rfe01 c0 z0",
               out_result, out_carry, out_zero);
    end
    drain();
    issue(3'b010, 8'd0, 8'd37);
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    checks++;
    if ({cyc, out_result, out_zero} !== {32'd9, 16'h0000, 1'b1}) begin
      errors++;
      $display("FAIL mul_0_37 got cyc%0d r%h z%b exp cyc9 r0000 z1",
               cyc, out_result, out_zero);
    end
    drain();
  endtask

  task automatic test_backpressure();
    int bad;
    bad = 0;
    issue(3'b000, 8'd1, 8'd1);
    in_valid = 1'b1;
    in_op    = 3'b001;
    in_a     = 8'd9;
    in_b     = 8'd3;
    for (int i = 0; i < 5; i++) begin
      if ({out_valid, out_result, in_ready} !== {1'b1, 16'h0002, 1'b0})
        bad++;
      tick();
    end
    checks++;
    if (bad != 0 ||
        {out_valid, out_result, in_ready} !== {1'b1, 16'h0002, 1'b0}) begin
      errors++;
      $display("FAIL hold_stable got bad%0d v%b r%h rdy%b exp v1 r0002 rdy0",
               bad, out_valid, out_result, in_ready);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL hold_release got v%b rdy%b exp v0 rdy1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_mul();
    int seen;
    seen = 0;
    issue(3'b010, 8'd200, 8'd3);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midmul_rst_rdy got %b exp 0", in_ready);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (out_valid !== 1'b0) seen++;
      tick();
    end
    checks++;
    if (seen != 0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midmul_discard got seen%0d rdy%b exp seen0 rdy1",
               seen, in_ready);
    end
    issue(3'b000, 8'd3, 8'd4);
    checks++;
    if ({out_valid, out_result} !== {1'b1, 16'h0007}) begin
      errors++;
      $display("FAIL add_3_4 got v%b r%h exp v1 r0007",
               out_valid, out_result);
    end
    drain();
  endtask

  task automatic test_shift();
    issue(3'b110, 8'h81, 8'd7);
    checks++;
    if ({out_result, out_carry} !== {16'h4080, 1'b0}) begin
      errors++;
      $display("FAIL shl_81_7 got r%h c%b exp r4080 c0",
               out_result, out_carry);
    end
    drain();
    issue(3'b111, 8'h81, 8'd9);
    checks++;
    if (out_result !== 16'h0040) begin
      errors++;
      $display("FAIL shr_81_9 got %h exp 0040", out_result);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    issue(3'b000, 8'd255, 8'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    issue(3'b001, 8'd0, 8'd1);
    checks++;
    if ({out_valid, out_result, out_carry} !== {1'b1, 16'h00FF, 1'b1}) begin
      errors++;
      $display("FAIL b2b_sub got v%b r%h c%b exp v1 r00ff c1",
               out_valid, out_result, out_carry);
    end
    drain();
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 3'b000;
    in_a      = 8'd0;
    in_b      = 8'd0;
    out_ready = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_mul();
    test_backpressure();
    test_reset_mid_mul();
    test_shift();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
